// File: rtl/mips_pkg.sv
// Shared pipeline definitions: register-address widths, the zero register,
// the pending-load slot layout and the register-read match helper.
package mips_pkg;

   localparam int REG_AW_DEF = 5;
   // Slots store addresses at this width so one slot type serves any REG_AW up to it.
   localparam int REG_AW_MAX = 8;

   localparam logic [REG_AW_MAX-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                  valid;
      logic [REG_AW_MAX-1:0] rd;
   } pend_slot_t;

   // True when the ID instruction reads register x; register 0 never matches.
   function automatic logic reads_reg(input logic [REG_AW_MAX-1:0] rs,
                                      input logic [REG_AW_MAX-1:0] rt,
                                      input logic                  rs_used,
                                      input logic                  rt_used,
                                      input logic [REG_AW_MAX-1:0] x);
      return (x != REG_ZERO) && ((rs_used && (rs == x)) || (rt_used && (rt == x)));
   endfunction

endpackage

// File: rtl/hazard_pend_pipe.sv
// Shift register of loads that have left EX but whose data is not yet
// forwardable; reports whether any valid slot feeds the ID instruction.
module hazard_pend_pipe
   import mips_pkg::*;
#(
   parameter int DEPTH = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  pend_slot_t            push,
   input  logic [REG_AW_MAX-1:0] rs,
   input  logic [REG_AW_MAX-1:0] rt,
   input  logic                  rs_used,
   input  logic                  rt_used,
   output logic                  slot_hit
);

   generate
      if (DEPTH == 0) begin : g_none
         logic unused_ok;
         assign unused_ok = ^{clk, rst_n, push, rs, rt, rs_used, rt_used};
         assign slot_hit  = 1'b0;
      end else begin : g_pipe
         pend_slot_t slot_q [DEPTH];
         pend_slot_t slot_d [DEPTH];

         always_comb begin
            slot_d[0] = push;
            for (int i = 1; i < DEPTH; i++) begin
               slot_d[i] = slot_q[i-1];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  slot_q[i] <= '0;
               end
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  slot_q[i] <= slot_d[i];
               end
            end
         end

         // Any matching entry stalls, so the youngest match holds bubble until it drains.
         always_comb begin
            slot_hit = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
               if (slot_q[i].valid && reads_reg(rs, rt, rs_used, rt_used, slot_q[i].rd)) begin
                  slot_hit = 1'b1;
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detector with a LOAD_LAT-deep pending-load scoreboard.
// Optional stall statistics are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard
   import mips_pkg::*;
#(
   parameter int REG_AW   = REG_AW_DEF,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic              rs_used,
   input  logic              rt_used,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_valid,
   input  logic              flush,
   output logic              bubble,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  stall_events
);

   logic [REG_AW_MAX-1:0] rs_w;
   logic [REG_AW_MAX-1:0] rt_w;
   logic [REG_AW_MAX-1:0] ex_rd_w;
   logic                  ex_is_load;
   logic                  ex_hit;
   logic                  slot_hit;
   pend_slot_t            push;

   assign rs_w    = REG_AW_MAX'(rs);
   assign rt_w    = REG_AW_MAX'(rt);
   assign ex_rd_w = REG_AW_MAX'(ex_rd);

   assign ex_is_load = ex_valid & ex_mem_read;
   assign ex_hit     = ex_is_load & reads_reg(rs_w, rt_w, rs_used, rt_used, ex_rd_w);

   // A flushed load never reaches the slots; loads already past EX keep advancing.
   assign push.valid = ex_is_load & ~flush & (ex_rd_w != REG_ZERO);
   assign push.rd    = ex_rd_w;

   hazard_pend_pipe #(
      .DEPTH (LOAD_LAT - 1)
   ) u_pend (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .rs       (rs_w),
      .rt       (rt_w),
      .rs_used  (rs_used),
      .rt_used  (rt_used),
      .slot_hit (slot_hit)
   );

   assign bubble = ~flush & (ex_hit | slot_hit);

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] stall_events_q, stall_events_d;
   logic             bubble_prev_q, bubble_prev_d;

   // Both counters saturate at all-ones rather than wrapping.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      stall_events_d = stall_events_q;
      bubble_prev_d  = bubble;
      if (bubble && !(&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
      if (bubble && !bubble_prev_q && !(&stall_events_q)) begin
         stall_events_d = stall_events_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         stall_events_q <= '0;
         bubble_prev_q  <= 1'b0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         stall_events_q <= stall_events_d;
         bubble_prev_q  <= bubble_prev_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign stall_events = stall_events_q;
`else
   assign stall_cycles = '0;
   assign stall_events = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: four instances (LOAD_LAT 1..4, the last
// with a 2-bit counter for saturation) share one set of ID/EX inputs.
module tb_hazard_scoreboard;

`ifdef HAZARD_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       rs_used;
   logic       rt_used;
   logic [4:0] ex_rd;
   logic       ex_mem_read;
   logic       ex_valid;
   logic       flush;

   logic        bub1, bub2, bub3, bub4;
   logic [31:0] cyc1, cyc2, cyc3;
   logic [31:0] ev1, ev2, ev3;
   logic [1:0]  cyc4, ev4;

   int numAssert = 0;
   int numFail   = 0;

   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .flush(flush),
      .bubble(bub1), .stall_cycles(cyc1), .stall_events(ev1));

   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(32)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .flush(flush),
      .bubble(bub2), .stall_cycles(cyc2), .stall_events(ev2));

   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .flush(flush),
      .bubble(bub3), .stall_cycles(cyc3), .stall_events(ev3));

   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(2)) u_lat4 (
      .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .flush(flush),
      .bubble(bub4), .stall_cycles(cyc4), .stall_events(ev4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numAssert++;
      if (observed !== expected) begin
         numFail++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge and settle before the next rising edge.
   task automatic applyStimulus(input logic [4:0] rsV, input logic rsU,
                                input logic [4:0] rtV, input logic rtU,
                                input logic [4:0] exRdV, input logic exMr,
                                input logic exV, input logic flushV);
      @(negedge clk);
      rs = rsV; rs_used = rsU; rt = rtV; rt_used = rtU;
      ex_rd = exRdV; ex_mem_read = exMr; ex_valid = exV; flush = flushV;
      #1;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      rs = '0; rt = '0; rs_used = 1'b0; rt_used = 1'b0;
      ex_rd = '0; ex_mem_read = 1'b0; ex_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      rs = '0; rt = '0; rs_used = 1'b0; rt_used = 1'b0;
      ex_rd = '0; ex_mem_read = 1'b0; ex_valid = 1'b0; flush = 1'b0;
      #1;
      checkOutput("rst_bub3", {31'd0, bub3}, 32'd0);
      checkOutput("rst_cyc1", cyc1, 32'd0);
      checkOutput("rst_ev3", ev3, 32'd0);
      checkOutput("rst_cyc4", {30'd0, cyc4}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] single-cycle load-use and latency scaling");
      applyStimulus(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      checkOutput("lu_c0_bub1", {31'd0, bub1}, 32'd1);
      checkOutput("lu_c0_bub2", {31'd0, bub2}, 32'd1);
      checkOutput("lu_c0_bub3", {31'd0, bub3}, 32'd1);
      checkOutput("lu_c0_bub4", {31'd0, bub4}, 32'd1);
      applyStimulus(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_c1_bub1", {31'd0, bub1}, 32'd0);
      checkOutput("lu_c1_bub2", {31'd0, bub2}, 32'd1);
      checkOutput("lu_c1_bub3", {31'd0, bub3}, 32'd1);
      applyStimulus(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_c2_bub2", {31'd0, bub2}, 32'd0);
      checkOutput("lu_c2_bub3", {31'd0, bub3}, 32'd1);
      checkOutput("lu_c2_bub4", {31'd0, bub4}, 32'd1);
      applyStimulus(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_c3_bub3", {31'd0, bub3}, 32'd0);
      checkOutput("lu_c3_bub4", {31'd0, bub4}, 32'd1);
      checkOutput("lu_c3_cyc3", cyc3, STATS ? 32'd3 : 32'd0);
      checkOutput("lu_c3_ev3", ev3, STATS ? 32'd1 : 32'd0);
      checkOutput("lu_c3_cyc1", cyc1, STATS ? 32'd1 : 32'd0);
      checkOutput("lu_c3_cyc2", cyc2, STATS ? 32'd2 : 32'd0);
      applyStimulus(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_c4_bub4", {31'd0, bub4}, 32'd0);
      checkOutput("sat_cyc4", {30'd0, cyc4}, STATS ? 32'd3 : 32'd0);
      checkOutput("sat_ev4", {30'd0, ev4}, STATS ? 32'd1 : 32'd0);

      $display("[TB] dependent instruction entering one cycle late");
      resetDut();
      applyStimulus(5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
      checkOutput("late_c0_bub3", {31'd0, bub3}, 32'd0);
      applyStimulus(5'd6, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
      checkOutput("late_c1_bub3", {31'd0, bub3}, 32'd1);
      checkOutput("late_c1_bub1", {31'd0, bub1}, 32'd0);
      applyStimulus(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("late_c2_bub3", {31'd0, bub3}, 32'd1);
      applyStimulus(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("late_c3_bub3", {31'd0, bub3}, 32'd0);

      $display("[TB] register zero and unused operand");
      resetDut();
      applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      checkOutput("r0_c0_bub1", {31'd0, bub1}, 32'd0);
      applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("r0_c1_bub3", {31'd0, bub3}, 32'd0);
      applyStimulus(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      checkOutput("rtoff_c0_bub1", {31'd0, bub1}, 32'd0);
      applyStimulus(5'd3, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("rtoff_c1_bub3", {31'd0, bub3}, 32'd0);

      $display("[TB] flush of the EX load");
      resetDut();
      applyStimulus(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
      checkOutput("fl_c0_bub2", {31'd0, bub2}, 32'd0);
      applyStimulus(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("fl_c1_bub2", {31'd0, bub2}, 32'd0);
      checkOutput("fl_c1_bub3", {31'd0, bub3}, 32'd0);

      $display("[TB] flush does not freeze older slots");
      resetDut();
      applyStimulus(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      checkOutput("adv_c0_bub3", {31'd0, bub3}, 32'd0);
      applyStimulus(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("adv_c1_bub3", {31'd0, bub3}, 32'd0);
      applyStimulus(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("adv_c2_bub3", {31'd0, bub3}, 32'd1);
      applyStimulus(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("adv_c3_bub3", {31'd0, bub3}, 32'd0);

      $display("[TB] back-to-back loads");
      resetDut();
      applyStimulus(5'd10, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
      checkOutput("b2b_c0_bub3", {31'd0, bub3}, 32'd0);
      applyStimulus(5'd2, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
      checkOutput("b2b_c1_bub3", {31'd0, bub3}, 32'd1);
      checkOutput("b2b_c1_bub1", {31'd0, bub1}, 32'd1);
      applyStimulus(5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("b2b_c2_bub3", {31'd0, bub3}, 32'd1);
      checkOutput("b2b_c2_bub1", {31'd0, bub1}, 32'd0);
      applyStimulus(5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("b2b_c3_bub3", {31'd0, bub3}, 32'd1);
      applyStimulus(5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("b2b_c4_bub3", {31'd0, bub3}, 32'd0);

      $display("[TB] reset during a stall");
      resetDut();
      applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      checkOutput("mr_c0_bub3", {31'd0, bub3}, 32'd1);
      applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("mr_c1_bub3", {31'd0, bub3}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mr_now_bub3", {31'd0, bub3}, 32'd0);
      checkOutput("mr_now_cyc3", cyc3, 32'd0);
      checkOutput("mr_now_ev3", ev3, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("mr_next_bub3", {31'd0, bub3}, 32'd0);
      checkOutput("mr_next_cyc3", cyc3, 32'd0);
      checkOutput("mr_next_ev3", ev3, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", numAssert, numFail);
      $finish;
   end

endmodule
